// File: rtl/parking_occupancy_ctrl_pkg.sv
// Shared types and constants for the parking occupancy sequencer and its gate timer.
package parking_pkg;

    localparam int OCC_W   = 4;
    localparam int TIMER_W = 8;

    localparam logic [OCC_W-1:0] OP_INC_B = 4'b0000;
    localparam logic [OCC_W-1:0] OP_DEC_B = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADD    = 2'd1,
        COMMIT = 2'd2,
        GATE   = 2'd3
    } park_state_e;

    // A decrement (b = all ones) must carry out; an increment must not.
    function automatic logic expected_cout(input logic [OCC_W-1:0] b);
        return (b == OP_DEC_B);
    endfunction

endpackage

// File: rtl/parking_occupancy_ctrl_if.sv
// Operand/result bus between the occupancy sequencer (master) and the external ripple adder (slave).
interface parking_adder_if;
    import parking_pkg::*;

    logic [OCC_W-1:0] add_a;
    logic [OCC_W-1:0] add_b;
    logic             add_cin;
    logic [OCC_W-1:0] add_sum;
    logic             add_cout;

    modport master (
        output add_a,
        output add_b,
        output add_cin,
        input  add_sum,
        input  add_cout
    );

    modport slave (
        input  add_a,
        input  add_b,
        input  add_cin,
        output add_sum,
        output add_cout
    );

endinterface

// File: rtl/parking_occupancy_ctrl_gate_timer.sv
// Loadable down-counter that times how long the barrier stays raised; done flags a zero count.
module gate_timer
    import parking_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_r;

    // Counter register: load wins over decrement, and the count never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// Occupancy sequencer: turns entry/exit pulses into adder operands, commits the sum, and runs the barrier.
// Optional build macro PARK_FAULT_FLAG_EN adds a sticky fault output.
module parking_occupancy_ctrl
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 9,
    parameter int GATE_CYCLES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_req,
    input  logic             exit_req,
    parking_adder_if.master  adder,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             reject,
    output logic             busy
`ifdef PARK_FAULT_FLAG_EN
    ,
    output logic             fault
`endif
);

    localparam logic [OCC_W-1:0]   CAP_V     = OCC_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] GATE_LOAD = TIMER_W'(GATE_CYCLES - 1);

    park_state_e      state_r, state_n;
    logic [OCC_W-1:0] occ_r, occ_n;
    logic [OCC_W-1:0] add_a_r, add_a_n;
    logic [OCC_W-1:0] add_b_r, add_b_n;
    logic             add_cin_r, add_cin_n;
    logic             reject_r, reject_s;
    logic             gate_open_r;
    logic             busy_r;
    logic             timer_load_s;
    logic             timer_dec_s;
    logic             timer_done_s;
    logic             cout_bad_s;

    assign cout_bad_s = (adder.add_cout != expected_cout(add_b_r));

    gate_timer #(.W(TIMER_W)) u_gate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .load_val (GATE_LOAD),
        .dec      (timer_dec_s),
        .done     (timer_done_s)
    );

    // Next-state, operand and reject decode.
    always_comb begin
        state_n      = state_r;
        occ_n        = occ_r;
        add_a_n      = add_a_r;
        add_b_n      = add_b_r;
        add_cin_n    = add_cin_r;
        reject_s     = 1'b0;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        case (state_r)
            IDLE: begin
                // Exit has priority; a simultaneous entry is dropped and flagged.
                if (exit_req) begin
                    if (occ_r != '0) begin
                        add_a_n   = occ_r;
                        add_b_n   = OP_DEC_B;
                        add_cin_n = 1'b0;
                        reject_s  = entry_req;
                        state_n   = ADD;
                    end else begin
                        reject_s  = 1'b1;
                    end
                end else if (entry_req) begin
                    if (occ_r < CAP_V) begin
                        add_a_n   = occ_r;
                        add_b_n   = OP_INC_B;
                        add_cin_n = 1'b1;
                        state_n   = ADD;
                    end else begin
                        reject_s  = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ADD: begin
                state_n = COMMIT;
            end
            COMMIT: begin
                if (cout_bad_s) begin
                    reject_s = 1'b1;
                end else begin
                    occ_n    = adder.add_sum;
                end
                timer_load_s = 1'b1;
                state_n      = GATE;
            end
            GATE: begin
                if (timer_done_s) begin
                    state_n     = IDLE;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, occupancy, operand and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            occ_r       <= '0;
            add_a_r     <= '0;
            add_b_r     <= '0;
            add_cin_r   <= 1'b0;
            reject_r    <= 1'b0;
            gate_open_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            occ_r       <= occ_n;
            add_a_r     <= add_a_n;
            add_b_r     <= add_b_n;
            add_cin_r   <= add_cin_n;
            reject_r    <= reject_s;
            gate_open_r <= (state_n == GATE);
            busy_r      <= (state_n != IDLE);
        end
    end

`ifdef PARK_FAULT_FLAG_EN
    logic fault_r;
    logic fault_set_s;

    assign fault_set_s = ((state_r == IDLE) && exit_req && (occ_r == '0)) ||
                         ((state_r == COMMIT) && cout_bad_s);

    // Sticky fault flag; only the reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_r <= 1'b0;
        end else if (fault_set_s) begin
            fault_r <= 1'b1;
        end else begin
            fault_r <= fault_r;
        end
    end

    assign fault = fault_r;
`endif

    assign adder.add_a   = add_a_r;
    assign adder.add_b   = add_b_r;
    assign adder.add_cin = add_cin_r;
    assign occupancy     = occ_r;
    assign full          = (occ_r == CAP_V);
    assign empty         = (occ_r == '0);
    assign gate_open     = gate_open_r;
    assign reject        = reject_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl with a behavioural 4-bit adder on the operand bus.
module tb_parking_occupancy_ctrl;
    import parking_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       entry_req = 1'b0;
    logic       exit_req = 1'b0;
    logic       inj_fault = 1'b0;
    logic [3:0] occupancy;
    logic       full, empty, gate_open, reject, busy;
`ifdef PARK_FAULT_FLAG_EN
    logic       fault;
`endif
    logic [4:0] raw_sum;
    int         n_cmp = 0;
    int         n_bad = 0;

    parking_adder_if bus ();

    assign raw_sum      = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_cin};
    assign bus.add_sum  = raw_sum[3:0];
    assign bus.add_cout = raw_sum[4] ^ inj_fault;

    parking_occupancy_ctrl #(.CAPACITY(9), .GATE_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .entry_req (entry_req),
        .exit_req  (exit_req),
        .adder     (bus),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .gate_open (gate_open),
        .reject    (reject),
        .busy      (busy)
`ifdef PARK_FAULT_FLAG_EN
        ,
        .fault     (fault)
`endif
    );

    always #5 clk = ~clk;

    // Called at a negedge; the request is sampled by the next posedge (cycle N), returns at cycle N+1 negedge.
    task automatic pulse(input logic en, input logic ex);
        entry_req = en;
        exit_req  = ex;
        @(negedge clk);
        entry_req = 1'b0;
        exit_req  = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({occupancy, empty, full, gate_open, reject, busy} !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_status: occ=%0d empty=%b full=%b gate=%b rej=%b busy=%b required 0 1 0 0 0 0",
                     occupancy, empty, full, gate_open, reject, busy);
        end
        n_cmp++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_operands: a=%h b=%h cin=%b required 0 0 0", bus.add_a, bus.add_b, bus.add_cin);
        end
`ifdef PARK_FAULT_FLAG_EN
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fault: fault=%b required 0", fault);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_entry();
        pulse(1'b1, 1'b0);
        n_cmp++;
        if ({bus.add_a, bus.add_b, bus.add_cin, busy} !== {4'd0, 4'b0000, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL entry_operands: a=%h b=%h cin=%b busy=%b required 0 0 1 1",
                     bus.add_a, bus.add_b, bus.add_cin, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (occupancy !== 4'd0 || gate_open !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_cycle2: occ=%0d gate=%b required 0 0", occupancy, gate_open);
        end
        @(negedge clk);
        n_cmp++;
        if (occupancy !== 4'd1 || empty !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_commit: occ=%0d empty=%b required 1 0", occupancy, empty);
        end
        for (int c = 3; c <= 10; c++) begin
            n_cmp++;
            if (gate_open !== 1'b1) begin
                n_bad++;
                $display("FAIL entry_gate_c%0d: gate=%b required 1", c, gate_open);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (gate_open !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL entry_gate_close: gate=%b busy=%b required 0 0", gate_open, busy);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            pulse(1'b1, 1'b0);
            wait_idle();
        end
        n_cmp++;
        if (occupancy !== 4'd9 || full !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_full: occ=%0d full=%b required 9 1", occupancy, full);
        end
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (reject !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_reject: rej=%b busy=%b required 1 0", reject, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (reject !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_reject_width: rej=%b required 0", reject);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (gate_open !== 1'b0 || occupancy !== 4'd9) begin
                n_bad++;
                $display("FAIL fill_hold: gate=%b occ=%0d required 0 9", gate_open, occupancy);
            end
        end
    endtask

    task automatic test_simultaneous();
        int rej_cnt;
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, 1'b1);
            wait_idle();
        end
        n_cmp++;
        if (occupancy !== 4'd5 || full !== 1'b0) begin
            n_bad++;
            $display("FAIL exits_to_5: occ=%0d full=%b required 5 0", occupancy, full);
        end
        pulse(1'b1, 1'b1);
        n_cmp++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== {4'd5, 4'b1111, 1'b0}) begin
            n_bad++;
            $display("FAIL simul_operands: a=%h b=%h cin=%b required 5 f 0", bus.add_a, bus.add_b, bus.add_cin);
        end
        rej_cnt = (reject === 1'b1) ? 1 : 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            rej_cnt += (reject === 1'b1) ? 1 : 0;
        end
        n_cmp++;
        if (rej_cnt != 1 || occupancy !== 4'd4) begin
            n_bad++;
            $display("FAIL simul_result: rejects=%0d occ=%0d required 1 4", rej_cnt, occupancy);
        end
    endtask

    task automatic test_gate_ignore();
        int rej_cnt;
        pulse(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (gate_open !== 1'b1 || occupancy !== 4'd3) begin
            n_bad++;
            $display("FAIL ignore_setup: gate=%b occ=%0d required 1 3", gate_open, occupancy);
        end
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || reject !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_busy: busy=%b rej=%b required 1 0", busy, reject);
        end
        rej_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            rej_cnt += (reject === 1'b1) ? 1 : 0;
        end
        n_cmp++;
        if (rej_cnt != 0 || occupancy !== 4'd3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_result: rejects=%0d occ=%0d busy=%b required 0 3 0", rej_cnt, occupancy, busy);
        end
    endtask

    task automatic test_cout_fault();
        int rej_cnt;
        inj_fault = 1'b1;
        pulse(1'b1, 1'b0);
        rej_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            rej_cnt += (reject === 1'b1) ? 1 : 0;
            @(negedge clk);
        end
        inj_fault = 1'b0;
        n_cmp++;
        if (rej_cnt != 1 || occupancy !== 4'd3) begin
            n_bad++;
            $display("FAIL cout_fault: rejects=%0d occ=%0d required 1 3", rej_cnt, occupancy);
        end
`ifdef PARK_FAULT_FLAG_EN
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL cout_fault_flag: fault=%b required 1", fault);
        end
`endif
    endtask

    task automatic test_reset_mid_gate();
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0);
            wait_idle();
        end
        n_cmp++;
        if (occupancy !== 4'd7) begin
            n_bad++;
            $display("FAIL midreset_setup: occ=%0d required 7", occupancy);
        end
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        pulse(1'b1, 1'b0);
        wait_idle();
        pulse(1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (occupancy !== 4'd7 || gate_open !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_in_gate: occ=%0d gate=%b required 7 1", occupancy, gate_open);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (occupancy !== 4'd0 || gate_open !== 1'b0 || busy !== 1'b0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_async: occ=%0d gate=%b busy=%b empty=%b required 0 0 0 1",
                     occupancy, gate_open, busy, empty);
        end
`ifdef PARK_FAULT_FLAG_EN
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_fault: fault=%b required 0", fault);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_empty_exit();
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (reject !== 1'b1 || empty !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_exit: rej=%b empty=%b busy=%b required 1 1 0", reject, empty, busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (reject !== 1'b0 || occupancy !== 4'd0) begin
            n_bad++;
            $display("FAIL empty_exit_after: rej=%b occ=%0d required 0 0", reject, occupancy);
        end
`ifdef PARK_FAULT_FLAG_EN
        n_cmp++;
        if (fault !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_exit_fault: fault=%b required 1", fault);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL fault_clear: fault=%b required 0", fault);
        end
`endif
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_entry();
        test_fill();
        test_simultaneous();
        test_gate_ignore();
        test_cout_fault();
        test_reset_mid_gate();
        test_empty_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
